// File: rtl/drlp_req_sched_if.sv
// Outgoing request port of the drlp mesh endpoint: one packet channel
// toward bsg_manycore_endpoint_standard plus the load-return strobe.
interface drlp_req_sched_if #(
    parameter int x_cord_width_p = 6,
    parameter int y_cord_width_p = 5,
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 26
) ();
    logic                      out_v;
    logic                      out_store;
    logic [addr_width_p-1:0]   out_addr;
    logic [data_width_p-1:0]   out_data;
    logic [x_cord_width_p-1:0] out_x;
    logic [y_cord_width_p-1:0] out_y;
    logic                      out_ready;
    logic                      returned_v;

    modport master (
        output out_v, out_store, out_addr, out_data, out_x, out_y,
        input  out_ready, returned_v
    );

    modport slave (
        input  out_v, out_store, out_addr, out_data, out_x, out_y,
        output out_ready, returned_v
    );
endinterface

// File: rtl/drlp_req_sched.sv
// Request-port sequencer for drlp: round-robin store/load arbitration, load credits,
// and a finish store held back until all loads return. Optional stats: DRLP_SCHED_STATS_EN.
module drlp_req_sched #(
    parameter int x_cord_width_p = 6,
    parameter int y_cord_width_p = 5,
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 26,
    parameter int max_rd_out_p   = 16,
    localparam int cw_lp         = $clog2(max_rd_out_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [x_cord_width_p-1:0] dest_x_i,
    input  logic [y_cord_width_p-1:0] dest_y_i,
    input  logic                      wr_v_i,
    input  logic [31:0]               wr_addr_i,
    input  logic [data_width_p-1:0]   wr_data_i,
    output logic                      wr_yumi_o,
    input  logic                      rd_v_i,
    input  logic [31:0]               rd_addr_i,
    output logic                      rd_yumi_o,
    input  logic                      fin_v_i,
    input  logic [31:0]               fin_word_i,
    output logic                      fin_yumi_o,
    drlp_req_sched_if.master          out_if,
`ifdef DRLP_SCHED_STATS_EN
    output logic [31:0]               st_cnt_o,
    output logic [31:0]               ld_cnt_o,
`endif
    output logic [cw_lp-1:0]          rd_credits_o,
    output logic                      busy_o,
    output logic                      underflow_o
);
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FIN} state_e;

    localparam logic [cw_lp-1:0] max_cred_lp = cw_lp'(max_rd_out_p);

    state_e            state_q;
    logic              rr_rd_q;      // 1: load wins the next tie
    logic [31:0]       fin_q;
    logic [cw_lp-1:0]  cred_q;
    logic [cw_lp-1:0]  cred_nxt;
    logic              uf_q;

    logic in_run, in_fin;
    logic wr_cand, rd_cand, gnt_wr, gnt_rd;
    logic out_v, fire, load_fire;

    assign in_run  = ~reset_i & (state_q == ST_RUN);
    assign in_fin  = ~reset_i & (state_q == ST_FIN);
    assign wr_cand = in_run & wr_v_i;
    assign rd_cand = in_run & rd_v_i & (cred_q < max_cred_lp);
    assign gnt_wr  = wr_cand & (~rd_cand | ~rr_rd_q);
    assign gnt_rd  = rd_cand & ~gnt_wr;

    assign out_v     = gnt_wr | gnt_rd | in_fin;
    assign fire      = out_v & out_if.out_ready;
    assign load_fire = fire & gnt_rd;

    assign wr_yumi_o    = fire & gnt_wr;
    assign rd_yumi_o    = load_fire;
    assign fin_yumi_o   = in_run & fin_v_i;
    assign busy_o       = ~reset_i & (state_q != ST_RUN);
    assign rd_credits_o = cred_q;
    assign underflow_o  = uf_q;

    // A simultaneous issue and return cancel; a return at zero leaves the count at zero.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        cred_nxt = cred_q;
        if (load_fire && !out_if.returned_v)
            cred_nxt = cred_q + 1'b1;
        else if (!load_fire && out_if.returned_v && cred_q != '0)
            cred_nxt = cred_q - 1'b1;
    end

    logic [31:0] fin_addr32, fin_x32, fin_y32;
    assign fin_addr32 = {18'b0, fin_q[15:2]};
    assign fin_x32    = {24'b0, fin_q[31:24]};
    assign fin_y32    = {24'b0, fin_q[23:16]};

    // Fields come straight from the held requester inputs, so they stay put under backpressure.
    always_comb begin
        out_if.out_v     = out_v;
        out_if.out_store = 1'b0;
        out_if.out_addr  = '0;
        out_if.out_data  = '0;
        out_if.out_x     = '0;
        out_if.out_y     = '0;
        if (in_fin) begin
            out_if.out_store = 1'b1;
            out_if.out_addr  = fin_addr32[addr_width_p-1:0];
            out_if.out_data  = data_width_p'(1);
            out_if.out_x     = fin_x32[x_cord_width_p-1:0];
            out_if.out_y     = fin_y32[y_cord_width_p-1:0];
        end else if (gnt_wr) begin
            out_if.out_store = 1'b1;
            out_if.out_addr  = wr_addr_i[addr_width_p-1:0];
            out_if.out_data  = wr_data_i;
            out_if.out_x     = dest_x_i;
            out_if.out_y     = dest_y_i;
        end else if (gnt_rd) begin
            out_if.out_addr  = rd_addr_i[addr_width_p-1:0];
            out_if.out_x     = dest_x_i;
            out_if.out_y     = dest_y_i;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_RUN;
            rr_rd_q <= 1'b0;
            fin_q   <= '0;
            cred_q  <= '0;
            uf_q    <= 1'b0;
        end else begin
            cred_q <= cred_nxt;
            if (out_if.returned_v && cred_q == '0)
                uf_q <= 1'b1;
            if (fire && gnt_wr)
                rr_rd_q <= 1'b1;
            else if (fire && gnt_rd)
                rr_rd_q <= 1'b0;
            case (state_q)
                ST_RUN: if (fin_v_i) begin
                    fin_q   <= fin_word_i;
                    state_q <= ST_DRAIN;
                end
                ST_DRAIN: if (cred_nxt == '0) state_q <= ST_FIN;
                ST_FIN:   if (fire) state_q <= ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
        end
    end

`ifdef DRLP_SCHED_STATS_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            st_cnt_o <= '0;
            ld_cnt_o <= '0;
        end else begin
            if (fire && out_if.out_store) st_cnt_o <= st_cnt_o + 32'd1;
            if (load_fire)                ld_cnt_o <= ld_cnt_o + 32'd1;
        end
    end
`endif

    logic unused_bits;
    assign unused_bits = ^{wr_addr_i, rd_addr_i, fin_q[1:0]};
endmodule
